// File: rtl/step_period_decoder.sv
// step_period_decoder: measures step_in rising-edge period and decodes it to the nearest velocity index.
module step_period_decoder #(
  parameter int CNT_W = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 250000,
  parameter int MIN_PERIOD = 1000,
  parameter int unsigned TH [7] = '{93750, 46875, 26041, 18229, 14062, 10714, 8371}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_in,
  output logic [2:0]       vel_index,
  output logic [CNT_W-1:0] period,
  output logic             meas_valid,
  output logic             stalled
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  state_t state;
  logic [SYNC_STAGES-1:0] sync;
  logic sync_d, rise;
  logic [CNT_W-1:0] cnt, cand;
  logic [2:0] dec;
  always_comb begin
    rise = sync[SYNC_STAGES-1] & ~sync_d;
    cand = cnt + CNT_W'(1);
    dec = 3'd7;
    // descending scan so the highest threshold met wins; ties land on the lower index
    for (int i = 6; i >= 0; i--)
      dec = (cand >= CNT_W'(TH[i])) ? 3'(i) : dec;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      sync_d <= 1'b0;
      cnt <= '0;
      state <= IDLE;
      vel_index <= 3'd0;
      period <= '0;
      meas_valid <= 1'b0;
      stalled <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], step_in};
      sync_d <= sync[SYNC_STAGES-1];
      meas_valid <= 1'b0;
      if (state == IDLE) begin
        cnt <= '0;
        if (rise) state <= MEASURE;
      end else if (rise && cand >= MIN_P) begin
        period <= cand;
        vel_index <= dec;
        meas_valid <= 1'b1;
        stalled <= 1'b0;
        cnt <= '0;
      end else if (cnt == TO_MAX) begin
        stalled <= 1'b1;
        vel_index <= 3'd0;
        cnt <= '0;
        state <= IDLE;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_step_period_decoder.sv
// tb_step_period_decoder: scaled-parameter bench with an edge-timeline reference model.
module tb_step_period_decoder;
  localparam int TO = 5000;
  localparam int MINP = 20;
  localparam int L = 3;
  localparam int unsigned TH [7] = '{1875, 937, 521, 364, 281, 214, 167};
  logic clk = 0, rst = 1, step_in = 0;
  logic [2:0] vel_index;
  logic [31:0] period;
  logic meas_valid, stalled;
  step_period_decoder #(.CNT_W(32), .SYNC_STAGES(2), .TIMEOUT(TO), .MIN_PERIOD(MINP), .TH(TH)) dut (
    .clk(clk), .rst(rst), .step_in(step_in), .vel_index(vel_index),
    .period(period), .meas_valid(meas_valid), .stalled(stalled));
  always #5 clk = ~clk;
  int checks = 0, failures = 0, cyc = 0, strobes = 0, last_edge = 0;
  int seen_cyc = -1, seen_per = 0, seen_idx = 0;
  bit meas, m_valid, m_stall;
  int ref_c, stall_at, upd_at, upd_p, upd_i, m_vel, m_per;
  typedef struct { int sp; int idx; } vec_t;
  vec_t tbl [12];
  function automatic int decode(int p);
    for (int i = 0; i < 7; i++) if (p >= int'(TH[i])) return i;
    return 7;
  endfunction
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  // edge at bench cycle n shows up at the outputs L cycles later; intervals are exact
  function automatic void model_edge();
    if (meas && cyc - ref_c > TO) begin
      stall_at = ref_c + L + TO;
      meas = 0;
    end
    if (!meas) begin
      meas = 1;
      ref_c = cyc;
    end else if (cyc - ref_c >= MINP) begin
      upd_at = cyc + L;
      upd_p = cyc - ref_c;
      upd_i = decode(upd_p);
      ref_c = cyc;
    end
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      meas = 0; stall_at = -1; upd_at = -1;
      m_valid = 0; m_stall = 1; m_vel = 0; m_per = 0;
    end else begin
      m_valid = 0;
      if (upd_at == cyc) begin
        m_per = upd_p; m_vel = upd_i; m_stall = 0; m_valid = 1;
      end
      if (stall_at == cyc) begin
        m_stall = 1; m_vel = 0;
      end
      if (meas && cyc == ref_c + L + TO) begin
        m_stall = 1; m_vel = 0; meas = 0;
      end
    end
    if (meas_valid) begin
      strobes++; seen_cyc = cyc; seen_per = period; seen_idx = vel_index;
    end
    check("outputs", {meas_valid, stalled, vel_index, period}, {m_valid, m_stall, 3'(m_vel), 32'(m_per)});
  endtask
  task automatic pulse(input int sp);
    step_in = 1;
    last_edge = cyc;
    model_edge();
    tick();
    tick();
    step_in = 0;
    repeat (sp - 2) tick();
  endtask
  task automatic expect_strobe(input string nm, input int sp, input int idx);
    check({nm, " latency"}, seen_cyc, last_edge + L);
    check({nm, " period"}, seen_per, sp);
    check({nm, " index"}, seen_idx, idx);
  endtask
  initial begin
    int s0, sp;
    tbl = '{'{2500, 0}, '{1250, 1}, '{625, 2}, '{417, 3}, '{312, 4}, '{250, 5},
            '{179, 6}, '{156, 7}, '{1875, 0}, '{1874, 1}, '{167, 6}, '{166, 7}};
    repeat (3) begin
      step_in = ~step_in;
      tick();
    end
    step_in = 0;
    tick();
    check("reset stalled", stalled, 1);
    check("reset period", period, 0);
    rst = 0;
    repeat (5100) tick();
    check("idle strobes", strobes, 0);
    check("idle stalled", stalled, 1);
    foreach (tbl[k])
      for (int j = 0; j < 3; j++) begin
        pulse(tbl[k].sp);
        if (j > 0) expect_strobe($sformatf("sweep%0d", tbl[k].sp), tbl[k].sp, tbl[k].idx);
      end
    check("sweep stalled", stalled, 0);
    repeat (TO + 10) tick();
    check("pre-glitch stalled", stalled, 1);
    pulse(10);
    s0 = strobes;
    pulse(302);
    check("glitch no strobe", strobes, s0);
    pulse(250);
    expect_strobe("glitch", 312, 4);
    pulse(250);
    pulse(TO + L - 1);
    expect_strobe("pre-timeout", 250, 5);
    check("timeout early stalled", stalled, 0);
    tick();
    check("timeout stalled", stalled, 1);
    check("timeout vel", vel_index, 0);
    check("timeout period", period, 250);
    s0 = strobes;
    pulse(1250);
    check("restart no strobe", strobes, s0);
    pulse(TO);
    expect_strobe("restart", 1250, 1);
    check("restart stalled", stalled, 0);
    pulse(625);
    expect_strobe("coincident", TO, 0);
    check("coincident stalled", stalled, 0);
    pulse(300);
    expect_strobe("pre-reset", 625, 2);
    rst = 1;
    repeat (2) tick();
    check("midreset stalled", stalled, 1);
    check("midreset vel", vel_index, 0);
    check("midreset period", period, 0);
    rst = 0;
    s0 = strobes;
    pulse(625);
    check("post-reset no strobe", strobes, s0);
    pulse(625);
    expect_strobe("post-reset", 625, 2);
    for (int r = 0; r < 20; r++) begin
      sp = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 5, TO + 5) : $urandom_range(5, 2600);
      pulse(sp);
    end
    repeat (TO + 10) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/step_period_decoder.md
Name: step_period_decoder

Overview:
- Inverse of the velocity-to-period table: measures the period of an incoming step/pulse train and decodes it back to the 3-bit velocity index whose nominal period is closest.
- Used on the feedback/monitor path to confirm that the commanded step rate matches the generated one.
- Also reports the raw period and flags a stalled or absent input.

Parameters:
- CNT_W, 32, width of the period counter and the period output.
- SYNC_STAGES, 2, number of flip-flops in the input synchronizer (minimum 2).
- TIMEOUT, 250000, a count reaching this value with no edge declares a stall (5 ms at 50 MHz).
- MIN_PERIOD, 1000, shorter edge-to-edge intervals are rejected as glitches.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous, active-high reset
- step_in  in  1  asynchronous pulse train; rising edges are measured
- vel_index  out  3  decoded velocity index
- period  out  CNT_W  last accepted period, in clk cycles
- meas_valid  out  1  one-cycle strobe; new vel_index/period
- stalled  out  1  no accepted measurement since reset or last timeout

Behaviour:
- Reset is synchronous and active-high. On rst: vel_index=0, period=0, meas_valid=0, stalled=1, counter=0, synchronizer flops=0, state=IDLE.
- rst asserted mid-measurement discards the partial count.
- Input path: step_in passes through SYNC_STAGES flops. A rising edge is detected when sync_out=1 and its 1-cycle-delayed copy=0. The synchronizer delay is constant, so the measured period is unaffected.
- State IDLE: counter held at 0; meas_valid=0. A detected edge loads counter=0 and moves to MEASURE. No measurement is produced from this first edge.
- State MEASURE: counter increments every cycle, saturating at TIMEOUT-1.
  - On an edge, candidate = counter+1, which equals the exact number of cycles between edges.
  - If candidate < MIN_PERIOD: the edge is ignored and counting continues.
  - Otherwise, the next cycle sets period=candidate, vel_index=decode(candidate), meas_valid=1, stalled=0, counter=0, and the state stays MEASURE.
  - Latency is 1 clk from the detected edge to meas_valid.
- Timeout: counter==TIMEOUT-1 with no edge in the same cycle. The next cycle sets stalled=1, vel_index=0, period unchanged, state=IDLE, and meas_valid stays 0.
- An edge that coincides with counter==TIMEOUT-1 is accepted as a measurement of candidate=TIMEOUT; no timeout occurs.
- Decode uses unsigned compares against the integer floor of each midpoint between adjacent nominal periods. A tie (candidate equal to a threshold) maps to the lower index.
  - candidate >= 93750 -> 0
  - >= 46875 -> 1
  - >= 26041 -> 2
  - >= 18229 -> 3
  - >= 14062 -> 4
  - >= 10714 -> 5
  - >= 8371 -> 6
  - otherwise -> 7
- Candidates below 7813 but at or above MIN_PERIOD decode to 7 (overspeed is clamped).
- vel_index and period hold their values between strobes.
- meas_valid is never high for two consecutive cycles.
- Width rules: counter and candidate are CNT_W bits. TIMEOUT must fit in CNT_W. candidate+1 cannot overflow because of the saturation.

Test Plan:
- Reset/idle: hold rst 3 cycles with step_in toggling -> all outputs at reset values and stalled=1; after release with step_in=0 for 300000 cycles -> no meas_valid, stalled stays 1.
- Nominal sweep: rising edges every 125000, 62500, 31250, 20833, 15625, 12500, 8929, 7813 cycles, 3 edges each -> meas_valid exactly 1 clk after each non-first detected edge, period equal to the spacing, vel_index 0..7 respectively, stalled=0 after the first valid strobe.
- Threshold ties: spacings of 93750 and 93749 -> index 0 then 1; spacings of 8371 and 8370 -> index 6 then 7.
- Glitch reject: edges at t=0, t=500 and t=15625 -> the t=500 edge produces no strobe; the t=15625 edge gives period=15625, vel_index=4.
- Timeout: valid 12500-cycle edges, then silence -> stalled=1 and vel_index=0 exactly TIMEOUT cycles after the last edge (+1 register), period stays 12500. The next single edge gives no strobe; the following edge 62500 cycles later gives vel_index=1 and stalled=0.
- Coincident edge/timeout and mid-run reset: an edge exactly 250000 cycles after the previous edge -> meas_valid with period=250000, vel_index=0, no stall. rst pulsed during a 31250-cycle interval -> all outputs reset and the first post-reset edge yields no strobe.
